// File: rtl/equalizer_i2s_tx_if.sv
// Sample-in / I2S-out bundle of the equalizer transmit stage.
// The producer side (sample strobe, enable, flag clear) is the master;
// the serialiser that drives the I2S pins and status is the slave.
interface equalizer_i2s_tx_if #(
  parameter int DATA_BITS  = 16,
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic                 tx_enable;
  logic                 sample_valid;
  logic [DATA_BITS-1:0] sample_in;
  logic                 clear_flags;
  logic                 i2s_bclk;
  logic                 i2s_lrclk;
  logic                 i2s_sdata;
  logic [LVL_W-1:0]     fifo_level;
  logic                 overflow;
  logic                 underrun;

  modport master (
    output tx_enable, sample_valid, sample_in, clear_flags,
    input  i2s_bclk, i2s_lrclk, i2s_sdata, fifo_level, overflow, underrun
  );

  modport slave (
    input  tx_enable, sample_valid, sample_in, clear_flags,
    output i2s_bclk, i2s_lrclk, i2s_sdata, fifo_level, overflow, underrun
  );
endinterface

// File: rtl/equalizer_i2s_tx.sv
// Equalizer output stage: a small sample FIFO feeding a Philips-I2S
// serialiser. Each mono sample is sent on both left and right channels.
// One frame is 4*DATA_BITS clk (bclk = clk/2, 2*DATA_BITS bclk per frame),
// so with 16-bit data one frame matches one equalizer sample period.
module equalizer_i2s_tx #(
  parameter int DATA_BITS  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  equalizer_i2s_tx_if.slave bus
);

  localparam int FRAME_CLKS = 4 * DATA_BITS;
  localparam int CNT_W      = $clog2(FRAME_CLKS);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int LVL_W      = PTR_W + 1;
  localparam int SHIFT_W    = 2 * DATA_BITS;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_CLKS - 1);
  // Shift register loads when the counter enters slot 1 (I2S one-bit delay).
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(2);
  // First clk of slot DATA_BITS, where lrclk switches to the right channel.
  localparam logic [CNT_W-1:0] CNT_RIGHT = CNT_W'(2 * DATA_BITS);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

  // Frame timing
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_nxt;
  logic                 bclk_q;
  logic                 lrclk_q;
  logic [SHIFT_W-1:0]   shift_q;

  // FIFO
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [LVL_W-1:0]     level;

  // Per-edge events
  logic                 load_evt;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 pop;
  logic                 push;
  logic                 drop;
  logic [DATA_BITS-1:0] word;

  logic                 overflow_q;
  logic                 underrun_q;

  // Next counter value and the FIFO/serialiser events it triggers.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves
    // a value unassigned and no latch is inferred.
    cnt_nxt    = '0;
    fifo_empty = (level == '0);
    fifo_full  = (level == LVL_FULL);
    load_evt   = 1'b0;
    pop        = 1'b0;
    push       = 1'b0;
    drop       = 1'b0;
    word       = '0;

    if (bus.tx_enable) begin
      cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    end

    load_evt = bus.tx_enable && (cnt_nxt == CNT_LOAD);
    pop      = load_evt && !fifo_empty;
    // A full FIFO can still accept a write on the edge that pops the head.
    push     = bus.sample_valid && (!fifo_full || pop);
    drop     = bus.sample_valid && fifo_full && !pop;

    // Empty at the load edge sends silence; a same-edge write is not bypassed.
    if (pop) begin
      word = mem[rd_ptr];
    end
  end

  // Frame counter plus registered bclk/lrclk derived from its next value.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      cnt     <= '0;
      bclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      bclk_q  <= cnt_nxt[0];
      lrclk_q <= (cnt_nxt >= CNT_RIGHT);
    end
  end

  // Output shift register: load {word, word} at slot 1, shift on each bclk fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
    end else if (!bus.tx_enable) begin
      shift_q <= '0;
    end else if (load_evt) begin
      shift_q <= {word, word};
    end else if (!cnt_nxt[0]) begin
      shift_q <= {shift_q[SHIFT_W-2:0], 1'b0};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; the pointers and level define
    // which entries are valid, so stale contents are never read.
    if (push) begin
      mem[wr_ptr] <= bus.sample_in;
    end
  end

  // Sticky flags: a new event on the same edge as clear_flags keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (bus.clear_flags) begin
        overflow_q <= 1'b0;
      end
      if (load_evt && fifo_empty) begin
        underrun_q <= 1'b1;
      end else if (bus.clear_flags) begin
        underrun_q <= 1'b0;
      end
    end
  end

  assign bus.i2s_bclk   = bclk_q;
  assign bus.i2s_lrclk  = lrclk_q;
  assign bus.i2s_sdata  = shift_q[SHIFT_W-1];
  assign bus.fifo_level = level;
  assign bus.overflow   = overflow_q;
  assign bus.underrun   = underrun_q;

endmodule

// File: tb/tb_equalizer_i2s_tx.sv
// Bench for equalizer_i2s_tx. A queue-based reference model predicts every
// output each clk from the frame rules (slot -> bit index of the current word),
// and an I2S receiver decodes the serial stream back into words.
module tb_equalizer_i2s_tx;

  localparam int DB    = 16;
  localparam int FD    = 4;
  localparam int LVL_W = $clog2(FD) + 1;
  localparam int FRAME = 4 * DB;
  localparam int N_STEADY = 600;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  equalizer_i2s_tx_if #(.DATA_BITS(DB), .FIFO_DEPTH(FD)) bus ();

  equalizer_i2s_tx #(.DATA_BITS(DB), .FIFO_DEPTH(FD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state
  int            m_cnt;
  logic [DB-1:0] m_word;
  logic [DB-1:0] m_q[$];
  bit            m_ov;
  bit            m_ur;

  // Receiver state
  logic [DB-1:0] acc;
  logic [DB-1:0] left_w;
  bit            last_lr;
  bit            prev_bclk;
  bit            prev_lr;
  logic [DB-1:0] rx[$];
  int            lr_rise[$];

  typedef struct {
    logic             valid;
    logic [DB-1:0]    data;
    logic             clr;
    logic [LVL_W-1:0] exp_level;
    logic             exp_ov;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic void model_reset();
    m_cnt  = 0;
    m_word = '0;
    m_q.delete();
    m_ov   = 1'b0;
    m_ur   = 1'b0;
  endfunction

  // Serial bit for the current slot: left word in slots 1..DB, right word in
  // slots DB+1..2*DB-1 and slot 0 of the following frame.
  function automatic logic exp_sdata();
    int slot = m_cnt / 2;
    if (slot == 0)       return m_word[0];
    else if (slot <= DB) return m_word[DB - slot];
    else                 return m_word[2 * DB - slot];
  endfunction

  task automatic model_edge();
    bit ov_set = 1'b0;
    bit ur_set = 1'b0;
    if (rst) begin
      model_reset();
      return;
    end
    if (!bus.tx_enable) begin
      m_cnt  = 0;
      m_word = '0;
    end else begin
      m_cnt = (m_cnt + 1) % FRAME;
      if (m_cnt == 2) begin
        if (m_q.size() > 0) m_word = m_q.pop_front();
        else begin
          m_word = '0;
          ur_set = 1'b1;
        end
      end
    end
    if (bus.sample_valid) begin
      if (m_q.size() < FD) m_q.push_back(bus.sample_in);
      else ov_set = 1'b1;
    end
    m_ov = ov_set | (m_ov & !bus.clear_flags);
    m_ur = ur_set | (m_ur & !bus.clear_flags);
  endtask

  task automatic compare_outputs();
    logic [7:0] got;
    logic [7:0] want;
    got  = {bus.i2s_bclk, bus.i2s_lrclk, bus.i2s_sdata, bus.fifo_level, bus.overflow, bus.underrun};
    want = {1'(m_cnt % 2), 1'((m_cnt / 2) >= DB), exp_sdata(), LVL_W'(m_q.size()), m_ov, m_ur};
    check("outputs{bclk,lr,sd,lvl,ov,ur}", {24'h0, got}, {24'h0, want});
  endtask

  // I2S receiver: bits taken on bclk rise; an lrclk change at a rise marks
  // that rise's bit as the LSB of the channel just ended.
  task automatic decode();
    if (rst || !bus.tx_enable) begin
      last_lr = 1'b0;
    end else if (bus.i2s_bclk && !prev_bclk) begin
      acc = {acc[DB-2:0], bus.i2s_sdata};
      if (bus.i2s_lrclk != last_lr) begin
        if (!last_lr) left_w = acc;
        else begin
          check("right_eq_left", {16'h0, acc}, {16'h0, left_w});
          rx.push_back(left_w);
        end
        last_lr = bus.i2s_lrclk;
      end
    end
    if (bus.i2s_lrclk && !prev_lr) lr_rise.push_back(cyc);
    prev_bclk = bus.i2s_bclk;
    prev_lr   = bus.i2s_lrclk;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    compare_outputs();
    decode();
  endtask

  task automatic pulse_write(input logic [DB-1:0] d);
    bus.sample_valid = 1'b1;
    bus.sample_in    = d;
    step();
    bus.sample_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear_flags = 1'b1;
    step();
    bus.clear_flags = 1'b0;
  endtask

  task automatic wait_cnt(input int target, input string name);
    int n = 0;
    while (m_cnt != target && n < 2 * FRAME) begin
      step();
      n++;
    end
    check(name, 32'(m_cnt), 32'(target));
  endtask

  task automatic wait_rx(input int words, input int budget, input string name);
    int n = 0;
    while (rx.size() < words && n < budget) begin
      step();
      n++;
    end
    check(name, 32'(rx.size() >= words), 32'd1);
  endtask

  initial begin
    logic [DB-1:0] stim[N_STEADY];
    int            idx;
    int            n;
    int            max_lvl;

    rst              = 1'b1;
    bus.tx_enable    = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    bus.clear_flags  = 1'b0;
    acc = '0; left_w = '0; last_lr = 1'b0; prev_bclk = 1'b0; prev_lr = 1'b0;
    model_reset();
    step();
    step();
    check("reset_outputs", {24'h0, bus.i2s_bclk, bus.i2s_lrclk, bus.i2s_sdata,
                            bus.fifo_level, bus.overflow, bus.underrun}, 32'h0);
    rst = 1'b0;
    step();

    // ---- 1: reset mid-frame at cnt=37, level=3 ----
    for (int i = 1; i <= 4; i++) pulse_write(DB'(16'h1111 * i));
    bus.tx_enable = 1'b1;
    wait_cnt(37, "t1_reach_cnt37");
    check("t1_level_before_rst", 32'(bus.fifo_level), 32'd3);
    rst = 1'b1;
    #1;
    check("t1_async_rst_outputs", {24'h0, bus.i2s_bclk, bus.i2s_lrclk, bus.i2s_sdata,
                                   bus.fifo_level, bus.overflow, bus.underrun}, 32'h0);
    step();
    rst = 1'b0;
    check("t1_bclk_low_after_release", 32'(bus.i2s_bclk), 32'd0);
    step();
    check("t1_first_bclk_rise", 32'(bus.i2s_bclk), 32'd1);

    // ---- 2: single sample A5C3 on both channels, 64-clk period ----
    bus.tx_enable = 1'b0;
    step();
    pulse_clear();
    rx.delete();
    lr_rise.delete();
    pulse_write(16'hA5C3);
    bus.tx_enable = 1'b1;
    wait_rx(2, 3 * FRAME, "t2_frames_received");
    if (rx.size() >= 2) begin
      check("t2_word", {16'h0, rx[0]}, 32'h0000A5C3);
      check("t2_next_frame_silent", {16'h0, rx[1]}, 32'h0);
    end
    if (lr_rise.size() >= 2) check("t2_frame_period", 32'(lr_rise[1] - lr_rise[0]), 32'd64);
    else check("t2_lr_rises", 32'(lr_rise.size()), 32'd2);

    // ---- 3: overflow while disabled, then drain 1..4 ----
    tbl[0] = '{1'b1, 16'd1, 1'b0, 3'd1, 1'b0};
    tbl[1] = '{1'b1, 16'd2, 1'b0, 3'd2, 1'b0};
    tbl[2] = '{1'b1, 16'd3, 1'b0, 3'd3, 1'b0};
    tbl[3] = '{1'b1, 16'd4, 1'b0, 3'd4, 1'b0};
    tbl[4] = '{1'b1, 16'd5, 1'b0, 3'd4, 1'b1};
    tbl[5] = '{1'b0, 16'd0, 1'b1, 3'd4, 1'b0};
    tbl[6] = '{1'b1, 16'd9, 1'b1, 3'd4, 1'b1};
    tbl[7] = '{1'b0, 16'd0, 1'b0, 3'd4, 1'b1};
    bus.tx_enable = 1'b0;
    step();
    pulse_clear();
    for (int i = 0; i < 8; i++) begin
      bus.sample_valid = tbl[i].valid;
      bus.sample_in    = tbl[i].data;
      bus.clear_flags  = tbl[i].clr;
      step();
      check($sformatf("t3_vec%0d_level", i), 32'(bus.fifo_level), 32'(tbl[i].exp_level));
      check($sformatf("t3_vec%0d_overflow", i), 32'(bus.overflow), 32'(tbl[i].exp_ov));
    end
    bus.sample_valid = 1'b0;
    bus.clear_flags  = 1'b0;
    rx.delete();
    bus.tx_enable = 1'b1;
    wait_rx(5, 7 * FRAME, "t3_frames_received");
    if (rx.size() >= 5) begin
      for (int i = 0; i < 4; i++) check($sformatf("t3_word%0d", i), {16'h0, rx[i]}, 32'(i + 1));
      check("t3_sample5_not_sent", {16'h0, rx[4]}, 32'h0);
    end
    check("t3_underrun_after_drain", 32'(bus.underrun), 32'd1);

    // ---- 4: enable with empty FIFO, then clear ----
    bus.tx_enable = 1'b0;
    step();
    pulse_clear();
    check("t4_flags_cleared", {30'h0, bus.overflow, bus.underrun}, 32'h0);
    rx.delete();
    bus.tx_enable = 1'b1;
    wait_cnt(2, "t4_reach_load");
    check("t4_underrun_set", 32'(bus.underrun), 32'd1);
    wait_rx(1, 2 * FRAME, "t4_frame_received");
    if (rx.size() >= 1) check("t4_silent_word", {16'h0, rx[0]}, 32'h0);
    wait_cnt(10, "t4_reach_cnt10");
    pulse_clear();
    check("t4_underrun_cleared", 32'(bus.underrun), 32'd0);

    // ---- 5: write strobe on the load edge with empty FIFO ----
    wait_cnt(1, "t5_reach_cnt1");
    rx.delete();
    pulse_write(16'h1234);
    check("t5_underrun", 32'(bus.underrun), 32'd1);
    check("t5_level", 32'(bus.fifo_level), 32'd1);
    wait_rx(2, 3 * FRAME, "t5_frames_received");
    if (rx.size() >= 2) begin
      check("t5_current_frame_silent", {16'h0, rx[0]}, 32'h0);
      check("t5_next_frame_word", {16'h0, rx[1]}, 32'h00001234);
    end

    // ---- 6: steady state, one strobe per frame at a fixed phase ----
    bus.tx_enable = 1'b0;
    step();
    pulse_clear();
    rx.delete();
    for (int i = 0; i < N_STEADY; i++) stim[i] = DB'($urandom);
    pulse_write(stim[0]);
    bus.tx_enable = 1'b1;
    idx = 1;
    n = 0;
    max_lvl = 0;
    while (rx.size() < N_STEADY && n < (N_STEADY + 3) * FRAME) begin
      if (m_cnt == 39 && idx < N_STEADY) begin
        bus.sample_valid = 1'b1;
        bus.sample_in    = stim[idx];
        idx++;
      end
      step();
      bus.sample_valid = 1'b0;
      if (int'(bus.fifo_level) > max_lvl) max_lvl = int'(bus.fifo_level);
      n++;
    end
    check("t6_words_received", 32'(rx.size()), 32'(N_STEADY));
    check("t6_no_flags", {30'h0, bus.overflow, bus.underrun}, 32'h0);
    check("t6_level_at_most_1", 32'(max_lvl <= 1), 32'd1);
    n = 0;
    for (int i = 0; i < N_STEADY && i < rx.size(); i++) if (rx[i] !== stim[i]) n++;
    check("t6_stream_mismatches", 32'(n), 32'd0);

    // ---- 7: random enable/strobe/clear traffic against the model ----
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) bus.tx_enable = ~bus.tx_enable;
      bus.sample_valid = ($urandom_range(0, 23) == 0);
      bus.sample_in    = DB'($urandom);
      bus.clear_flags  = ($urandom_range(0, 79) == 0);
      step();
    end
    bus.sample_valid = 1'b0;
    bus.clear_flags  = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
